// File: rtl/size_conv_pkg.sv
// Shared constants for the byte-link size converters.
// Lane count helper returns 0 for unsupported word sizes.
package size_conv_pkg;

    localparam int BYTE_W  = 8;
    localparam int SIZE_8  = 8;
    localparam int SIZE_16 = 16;
    localparam int SIZE_32 = 32;
    localparam int CNT_W   = 2;

    function automatic int lanes(input int size);
        int n;
        n = 0;
        if (size == SIZE_8 || size == SIZE_16 || size == SIZE_32)
            n = size / BYTE_W;
        return n;
    endfunction

endpackage

// File: rtl/size_assemble_cond.sv
// Byte-to-word assembler: LSB-first bytes into SIZE-bit words,
// framed by LAST_IN, with a pulse on framing mismatch.
module size_assemble_cond
    import size_conv_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            PCLK,
    input  logic            RESET,
    input  logic [7:0]      DATA_IN,
    input  logic            VALID_IN,
    input  logic            LAST_IN,
    output logic [SIZE-1:0] DATA_OUT,
    output logic            VALID_OUT,
    output logic            BUSY,
    output logic            ERROR
);

    localparam int N     = lanes(SIZE);
    localparam bit OK    = (N != 0);
    localparam int BUF_W = (SIZE > BYTE_W) ? SIZE - BYTE_W : BYTE_W;
    localparam int NBUF  = BUF_W / BYTE_W;
    localparam logic [CNT_W-1:0] LAST_LANE = OK ? CNT_W'(N - 1) : '0;

    logic [CNT_W-1:0] count_q, count_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [SIZE-1:0]  data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;
    logic             at_last;
    logic [SIZE-1:0]  word;

    always_comb begin
        count_d = count_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        at_last = (count_q == LAST_LANE);
        // buffer sits in the low lanes; the final byte fills the top lane
        word    = SIZE'(buf_q);
        word[SIZE-1 -: BYTE_W] = DATA_IN;
        if (OK && VALID_IN) begin
            unique case (1'b1)
                (!at_last && !LAST_IN): begin
                    for (int i = 0; i < NBUF; i++)
                        if (count_q == CNT_W'(i))
                            buf_d[BYTE_W*i +: BYTE_W] = DATA_IN;
                    count_d = count_q + CNT_W'(1);
                end
                (at_last && LAST_IN): begin
                    data_d  = word;
                    valid_d = 1'b1;
                    count_d = '0;
                end
                (at_last != LAST_IN): begin
                    error_d = 1'b1;
                    count_d = '0;
                end
            endcase
        end
        busy_d = (count_d != '0);
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            count_q <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    assign DATA_OUT  = data_q;
    assign VALID_OUT = valid_q;
    assign BUSY      = busy_q;
    assign ERROR     = error_q;

endmodule

// File: tb/tb_size_assemble_cond.sv
// Directed bench for the byte-to-word assembler at SIZE 8, 16 and 32.
// Table-driven SIZE=32 run plus hand-written multi-cycle sequences.
module tb_size_assemble_cond;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       vin;
    logic       lin;

    logic [7:0]  d8;
    logic [15:0] d16;
    logic [31:0] d32;
    logic        vo8, vo16, vo32;
    logic        b8, b16, b32;
    logic        e8, e16, e32;

    int errors = 0;
    int checks = 0;

    size_assemble_cond #(.SIZE(8)) u8 (
        .PCLK(clk), .RESET(rst), .DATA_IN(din), .VALID_IN(vin),
        .LAST_IN(lin), .DATA_OUT(d8), .VALID_OUT(vo8), .BUSY(b8),
        .ERROR(e8)
    );
    size_assemble_cond #(.SIZE(16)) u16 (
        .PCLK(clk), .RESET(rst), .DATA_IN(din), .VALID_IN(vin),
        .LAST_IN(lin), .DATA_OUT(d16), .VALID_OUT(vo16), .BUSY(b16),
        .ERROR(e16)
    );
    size_assemble_cond #(.SIZE(32)) u32 (
        .PCLK(clk), .RESET(rst), .DATA_IN(din), .VALID_IN(vin),
        .LAST_IN(lin), .DATA_OUT(d32), .VALID_OUT(vo32), .BUSY(b32),
        .ERROR(e32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        l;
        logic [7:0]  d;
        logic [31:0] exp_data;
        logic        exp_vo;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic l, input logic [7:0] d);
        vin = v;
        lin = l;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = 1'b0;
        lin = 1'b0;
        din = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        vin = 1'b0;
        lin = 1'b0;
        din = 8'h00;

        tbl[0]  = '{1'b1, 1'b0, 8'h11, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h22, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h33, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 8'h44, 32'h44332211, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 32'h44332211, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'hAA, 32'h44332211, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 8'hBB, 32'h44332211, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 8'hEF, 32'h44332211, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'hBE, 32'h44332211, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'hAD, 32'h44332211, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'hDE, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'hFF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};

        // reset state of all three widths
        do_reset();
        chk("rst d32", d32, 32'h0);
        chk("rst vo32", {31'b0, vo32}, 32'h0);
        chk("rst b32", {31'b0, b32}, 32'h0);
        chk("rst e32", {31'b0, e32}, 32'h0);
        chk("rst d16", {16'h0, d16}, 32'h0);
        chk("rst d8", {24'h0, d8}, 32'h0);

        // SIZE=32 table: clean word, early last, clean word
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v, tbl[i].l, tbl[i].d);
            chk($sformatf("t%0d data", i), d32, tbl[i].exp_data);
            chk($sformatf("t%0d vo", i), {31'b0, vo32},
                {31'b0, tbl[i].exp_vo});
            chk($sformatf("t%0d busy", i), {31'b0, b32},
                {31'b0, tbl[i].exp_busy});
            chk($sformatf("t%0d err", i), {31'b0, e32},
                {31'b0, tbl[i].exp_err});
        end

        // SIZE=16 with a 3-cycle gap (LAST_IN toggled while idle)
        do_reset();
        cyc(1'b1, 1'b0, 8'hAB);
        chk("gap busy0", {31'b0, b16}, 32'h1);
        for (int g = 0; g < 3; g++) begin
            cyc(1'b0, 1'b1, 8'h77);
            chk($sformatf("gap busy%0d", g + 1), {31'b0, b16}, 32'h1);
            chk($sformatf("gap vo%0d", g + 1), {31'b0, vo16}, 32'h0);
            chk($sformatf("gap err%0d", g + 1), {31'b0, e16}, 32'h0);
        end
        cyc(1'b1, 1'b1, 8'hCD);
        chk("gap data", {16'h0, d16}, 32'h0000CDAB);
        chk("gap vo", {31'b0, vo16}, 32'h1);
        chk("gap busy", {31'b0, b16}, 32'h0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("gap vo off", {31'b0, vo16}, 32'h0);
        chk("gap hold", {16'h0, d16}, 32'h0000CDAB);

        // SIZE=16 missing last
        do_reset();
        cyc(1'b1, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        chk("ml err", {31'b0, e16}, 32'h1);
        chk("ml vo", {31'b0, vo16}, 32'h0);
        chk("ml busy", {31'b0, b16}, 32'h0);
        chk("ml data", {16'h0, d16}, 32'h0);
        cyc(1'b1, 1'b0, 8'h01);
        chk("ml err off", {31'b0, e16}, 32'h0);
        cyc(1'b1, 1'b1, 8'h02);
        chk("ml next data", {16'h0, d16}, 32'h00000201);
        chk("ml next vo", {31'b0, vo16}, 32'h1);

        // SIZE=32 reset mid-word, reset wins over a valid byte
        do_reset();
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'h66);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'h77);
        rst = 1'b0;
        chk("mr data", d32, 32'h0);
        chk("mr vo", {31'b0, vo32}, 32'h0);
        chk("mr busy", {31'b0, b32}, 32'h0);
        chk("mr err", {31'b0, e32}, 32'h0);
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        cyc(1'b1, 1'b1, 8'h04);
        chk("mr next data", d32, 32'h04030201);
        chk("mr next vo", {31'b0, vo32}, 32'h1);
        chk("mr next err", {31'b0, e32}, 32'h0);

        // SIZE=8 streaming, every byte is a word
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1, 8'(k));
            chk($sformatf("s8 data%0d", k), {24'h0, d8}, 32'(k));
            chk($sformatf("s8 vo%0d", k), {31'b0, vo8}, 32'h1);
            chk($sformatf("s8 busy%0d", k), {31'b0, b8}, 32'h0);
        end
        cyc(1'b1, 1'b0, 8'h5A);
        chk("s8 ml err", {31'b0, e8}, 32'h1);
        chk("s8 ml vo", {31'b0, vo8}, 32'h0);
        chk("s8 ml data", {24'h0, d8}, 32'h0000000F);
        cyc(1'b0, 1'b0, 8'h00);
        chk("s8 err off", {31'b0, e8}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
